// File: rtl/serial_tx_ctrl_pkg.sv
// Shared definitions for the serial transmit controller: state encoding and
// the counter width helper.
package serial_tx_ctrl_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_DONE  = DONE
   } state_t;

   // Bits needed to count 0..v-1, never less than one.
   function automatic int cnt_width(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out right-shift register. Load has priority over shift;
// the register holds when neither is asserted.
module shift_register_piso #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         shift_en,
   input  logic         SI,
   input  logic [N-1:0] I,
   output logic [N-1:0] Q,
   output logic         SO
);

   logic [N-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= I;
      end else if (shift_en) begin
         q_reg <= {SI, q_reg[N-1:1]};
      end
   end

   assign Q  = q_reg;
   assign SO = q_reg[0];

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serializes one parallel word LSB first, holding each bit for DIV cycles,
// with a valid/ready intake, abort and a one-cycle done pulse per frame.
module serial_tx_ctrl
   import serial_tx_ctrl_pkg::*;
#(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         abort,
   output logic         so,
   output logic         so_valid,
   output logic         busy,
   output logic         done
);

   localparam int DW = cnt_width(DIV);
   localparam int BW = cnt_width(N);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

   state_t        state_reg;
   logic [DW-1:0] div_cnt_reg;
   logic [BW-1:0] bit_cnt_reg;
   logic          din_ready_reg;
   logic          so_valid_reg;
   logic          busy_reg;
   logic          done_reg;

   logic          accept;
   logic          div_wrap;
   logic          load;
   logic          shift_en;
   logic [N-1:0]  load_word;
   logic [N-1:0]  q_unused;
   logic          sr_so;

   assign accept    = (state_reg == ST_IDLE) && din_valid;
   assign div_wrap  = (div_cnt_reg == DIV_LAST);
   // An abort reuses the load path with a zero word to clear the register.
   assign load      = accept || ((state_reg == ST_SHIFT) && abort);
   assign load_word = accept ? din : '0;
   assign shift_en  = (state_reg == ST_SHIFT) && div_wrap && !abort;

   shift_register_piso #(
      .N (N)
   ) u_piso (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .shift_en (shift_en),
      .SI       (1'b0),
      .I        (load_word),
      .Q        (q_unused),
      .SO       (sr_so)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         div_cnt_reg   <= '0;
         bit_cnt_reg   <= '0;
         din_ready_reg <= 1'b1;
         so_valid_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (din_valid) begin
                  state_reg     <= ST_SHIFT;
                  div_cnt_reg   <= '0;
                  bit_cnt_reg   <= '0;
                  din_ready_reg <= 1'b0;
                  so_valid_reg  <= 1'b1;
                  busy_reg      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  state_reg     <= ST_IDLE;
                  div_cnt_reg   <= '0;
                  bit_cnt_reg   <= '0;
                  din_ready_reg <= 1'b1;
                  so_valid_reg  <= 1'b0;
                  busy_reg      <= 1'b0;
               end else if (div_wrap) begin
                  div_cnt_reg <= '0;
                  if (bit_cnt_reg == BIT_LAST) begin
                     state_reg    <= ST_DONE;
                     bit_cnt_reg  <= '0;
                     so_valid_reg <= 1'b0;
                     done_reg     <= 1'b1;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DW'(1);
               end
            end
            ST_DONE: begin
               state_reg     <= ST_IDLE;
               din_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
            default: begin
               state_reg     <= ST_IDLE;
               din_ready_reg <= 1'b1;
               so_valid_reg  <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   // The register is all zeros outside SHIFT, so its LSB drives the line directly.
   assign so        = sr_so;
   assign so_valid  = so_valid_reg;
   assign din_ready = din_ready_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl: three instances cover N=4/DIV=2,
// N=4/DIV=1 and N=8/DIV=3.
module tb_serial_tx_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] a_din;
   logic       a_valid, a_abort, a_ready, a_so, a_sov, a_busy, a_done;
   logic [3:0] b_din;
   logic       b_valid, b_abort, b_ready, b_so, b_sov, b_busy, b_done;
   logic [7:0] c_din;
   logic       c_valid, c_abort, c_ready, c_so, c_sov, c_busy, c_done;

   logic [7:0] exp_bits;

   always #5 clk = ~clk;

   serial_tx_ctrl #(.N(4), .DIV(2)) u_a (
      .clk(clk), .reset_n(rst_n), .din(a_din), .din_valid(a_valid),
      .din_ready(a_ready), .abort(a_abort), .so(a_so), .so_valid(a_sov),
      .busy(a_busy), .done(a_done)
   );

   serial_tx_ctrl #(.N(4), .DIV(1)) u_b (
      .clk(clk), .reset_n(rst_n), .din(b_din), .din_valid(b_valid),
      .din_ready(b_ready), .abort(b_abort), .so(b_so), .so_valid(b_sov),
      .busy(b_busy), .done(b_done)
   );

   serial_tx_ctrl #(.N(8), .DIV(3)) u_c (
      .clk(clk), .reset_n(rst_n), .din(c_din), .din_valid(c_valid),
      .din_ready(c_ready), .abort(c_abort), .so(c_so), .so_valid(c_sov),
      .busy(c_busy), .done(c_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packs {din_ready, busy, so_valid, so, done} for compact state checks.
   function automatic logic [4:0] pk(input logic r, input logic b, input logic v,
                                     input logic s, input logic d);
      return {r, b, v, s, d};
   endfunction

   initial begin
      rst_n = 1'b0;
      a_din = '0; a_valid = 1'b0; a_abort = 1'b0;
      b_din = '0; b_valid = 1'b0; b_abort = 1'b0;
      c_din = '0; c_valid = 1'b0; c_abort = 1'b0;
      tick(); tick();

      chk("reset_a", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);
      chk("reset_b", pk(b_ready, b_busy, b_sov, b_so, b_done), 5'b10000);
      chk("reset_c", pk(c_ready, c_busy, c_sov, c_so, c_done), 5'b10000);
      rst_n = 1'b1;
      tick();
      chk("idle_hold_a", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);

      // Reset mid-frame: reset lands in the 3rd so_valid cycle.
      a_din = 4'b1011; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("rmf_c1", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b01110);
      tick();
      chk("rmf_c2", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b01110);
      tick();
      chk("rmf_c3", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b01110);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rmf_after", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("rmf_nodone_%0d", i), pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);
      end

      // Single frame 4'b1011, DIV=2; din changes after accept must not matter.
      exp_bits = 8'b1100_1111;
      a_din = 4'b1011; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      a_din = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("sf_bit_%0d", i), pk(a_ready, a_busy, a_sov, a_so, a_done),
             pk(1'b0, 1'b1, 1'b1, exp_bits[i], 1'b0));
         tick();
      end
      chk("sf_done", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b01001);
      tick();
      chk("sf_idle", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);

      // Ignore din_valid while busy on a frame of all zeros.
      a_din = 4'h0; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin a_din = 4'hF; a_valid = 1'b1; end
         if (i == 2) a_valid = 1'b0;
         chk($sformatf("ign_bit_%0d", i), pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b01100);
         tick();
      end
      chk("ign_done", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b01001);
      tick();
      chk("ign_idle", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);
      tick();
      chk("ign_no_frame", pk(a_ready, a_busy, a_sov, a_so, a_done), 5'b10000);

      // Back-to-back, DIV=1: din_valid held, 4'hA then 4'h5.
      b_din = 4'hA; b_valid = 1'b1;
      tick();
      b_din = 4'h5;
      exp_bits = 8'b0101_1010;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_f1_bit_%0d", i), pk(b_ready, b_busy, b_sov, b_so, b_done),
             pk(1'b0, 1'b1, 1'b1, exp_bits[i], 1'b0));
         tick();
      end
      chk("b2b_f1_done", pk(b_ready, b_busy, b_sov, b_so, b_done), 5'b01001);
      tick();
      chk("b2b_idle", pk(b_ready, b_busy, b_sov, b_so, b_done), 5'b10000);
      tick();
      b_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_f2_bit_%0d", i), pk(b_ready, b_busy, b_sov, b_so, b_done),
             pk(1'b0, 1'b1, 1'b1, exp_bits[4+i], 1'b0));
         tick();
      end
      chk("b2b_f2_done", pk(b_ready, b_busy, b_sov, b_so, b_done), 5'b01001);
      tick();
      chk("b2b_f2_idle", pk(b_ready, b_busy, b_sov, b_so, b_done), 5'b10000);

      // Abort, N=8 DIV=3, 8'hFF: abort in the 5th SHIFT cycle.
      c_din = 8'hFF; c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("abt_shift_%0d", i), pk(c_ready, c_busy, c_sov, c_so, c_done), 5'b01110);
         if (i == 4) c_abort = 1'b1;
         tick();
      end
      c_abort = 1'b0;
      chk("abt_idle", pk(c_ready, c_busy, c_sov, c_so, c_done), 5'b10000);
      for (int i = 0; i < 24; i++) begin
         tick();
         chk($sformatf("abt_nodone_%0d", i), {31'd0, c_done}, 32'd0);
      end

      // Abort coinciding with an accept in IDLE is ignored; frame runs to done.
      c_din = 8'h01; c_valid = 1'b1; c_abort = 1'b1;
      tick();
      c_valid = 1'b0; c_abort = 1'b0;
      chk("abt_idle_accept", pk(c_ready, c_busy, c_sov, c_so, c_done), 5'b01110);
      for (int i = 0; i < 24; i++) tick();
      chk("abt_idle_done", pk(c_ready, c_busy, c_sov, c_so, c_done), 5'b01001);
      tick();
      chk("abt_idle_ready", pk(c_ready, c_busy, c_sov, c_so, c_done), 5'b10000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
